// File: rtl/exe_pkg.sv
// Shared constants for the ARM-subset execute stage:
// ALU opcodes, shift types, status-register bit positions.
package exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // rotate right; doubling the word keeps amt==0 well defined
  function automatic logic [31:0] ror32(
    input logic [31:0] v,
    input logic [4:0]  amt
  );
    logic [63:0] w;
    w = {v, v} >> amt;
    return w[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second-operand generator: memory offset, rotated
// immediate, or shifted register.
module val2_generator
  import exe_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0]  w_sh_amt;
  logic [1:0]  w_sh_typ;
  logic [4:0]  w_rot;
  logic [31:0] w_imm8;

  assign w_sh_amt = shift_operand[11:7];
  assign w_sh_typ = shift_operand[6:5];
  assign w_rot    = {shift_operand[11:8], 1'b0};
  assign w_imm8   = {24'b0, shift_operand[7:0]};

  // priority: memory offset, then immediate, then shifter
  always_comb begin
    val2 = val_rm;
    if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = ror32(w_imm8, w_rot);
    end else begin
      case (w_sh_typ)
        SH_LSL:  val2 = val_rm << w_sh_amt;
        SH_LSR:  val2 = val_rm >> w_sh_amt;
        SH_ASR:  val2 = $signed(val_rm) >>> w_sh_amt;
        default: val2 = ror32(val_rm, w_sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, status register, branch target,
// EXE/MEM register. EXE_FWD_EN adds the operand forwarding mux.
module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
`ifdef EXE_FWD_EN
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
`endif
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        sr,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm,
  output logic [REG_AW-1:0] dest
);

  logic [31:0] w_rn;
  logic [31:0] w_rm;
  logic [31:0] w_val2;
  logic [31:0] w_res;
  logic [32:0] w_wide;
  logic        w_c;
  logic        w_v;
  logic        w_known;
  logic [3:0]  w_sr_nxt;

  logic [3:0]        r_sr;
  logic              r_wb_en;
  logic              r_mem_r_en;
  logic              r_mem_w_en;
  logic [31:0]       r_alu_res;
  logic [31:0]       r_val_rm;
  logic [REG_AW-1:0] r_dest;

`ifdef EXE_FWD_EN
  // operand forwarding from MEM and WB
  always_comb begin
    case (sel_src1)
      2'b01:   w_rn = mem_fwd_val;
      2'b10:   w_rn = wb_fwd_val;
      default: w_rn = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   w_rm = mem_fwd_val;
      2'b10:   w_rm = wb_fwd_val;
      default: w_rm = val_rm_in;
    endcase
  end
`else
  assign w_rn = val_rn_in;
  assign w_rm = val_rm_in;
`endif

  val2_generator u_val2 (
    .val_rm        (w_rm),
    .shift_operand (shift_operand_in),
    .imm           (imm_in),
    .mem_en        (mem_r_en_in | mem_w_en_in),
    .val2          (w_val2)
  );

  assign branch_taken = b_in;
  assign branch_addr  = pc_in +
    {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  // ALU: result plus C/V; logical ops keep C/V from sr
  always_comb begin
    w_res   = 32'b0;
    w_wide  = 33'b0;
    w_c     = r_sr[SR_C];
    w_v     = r_sr[SR_V];
    w_known = 1'b1;
    case (exe_cmd_in)
      EXE_MOV: w_res = w_val2;
      EXE_MVN: w_res = ~w_val2;
      EXE_ADD, EXE_ADC: begin
        w_wide = {1'b0, w_rn} + {1'b0, w_val2} +
          {32'b0, (exe_cmd_in == EXE_ADC) & r_sr[SR_C]};
        w_res = w_wide[31:0];
        w_c   = w_wide[32];
        w_v   = (w_rn[31] == w_val2[31]) &
                (w_res[31] != w_rn[31]);
      end
      EXE_SUB, EXE_SBC: begin
        w_wide = {1'b0, w_rn} - {1'b0, w_val2} -
          {32'b0, (exe_cmd_in == EXE_SBC) & ~r_sr[SR_C]};
        w_res = w_wide[31:0];
        w_c   = ~w_wide[32];
        w_v   = (w_rn[31] != w_val2[31]) &
                (w_res[31] != w_rn[31]);
      end
      EXE_AND: w_res = w_rn & w_val2;
      EXE_ORR: w_res = w_rn | w_val2;
      EXE_EOR: w_res = w_rn ^ w_val2;
      default: w_known = 1'b0;
    endcase
  end

  // undefined opcodes leave every flag untouched
  always_comb begin
    w_sr_nxt = r_sr;
    if (w_known) begin
      w_sr_nxt[SR_N] = w_res[31];
      w_sr_nxt[SR_Z] = (w_res == 32'b0);
      w_sr_nxt[SR_C] = w_c;
      w_sr_nxt[SR_V] = w_v;
    end
  end

  // status register: reset, then freeze, then S bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr <= 4'b0;
    end else if (!freeze && s_in) begin
      r_sr <= w_sr_nxt;
    end
  end

  // EXE/MEM pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= 32'b0;
      r_val_rm   <= 32'b0;
      r_dest     <= '0;
    end else if (!freeze) begin
      r_wb_en    <= wb_en_in;
      r_mem_r_en <= mem_r_en_in;
      r_mem_w_en <= mem_w_en_in;
      r_alu_res  <= w_res;
      r_val_rm   <= w_rm;
      r_dest     <= dest_in;
    end
  end

  assign sr       = r_sr;
  assign wb_en    = r_wb_en;
  assign mem_r_en = r_mem_r_en;
  assign mem_w_en = r_mem_w_en;
  assign alu_res  = r_alu_res;
  assign val_rm   = r_val_rm;
  assign dest     = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a
// scoreboard queue, plus reset and freeze sequences.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  sr;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .wb_en_in         (wb_en_in),
    .mem_r_en_in      (mem_r_en_in),
    .mem_w_en_in      (mem_w_en_in),
    .b_in             (b_in),
    .s_in             (s_in),
    .exe_cmd_in       (exe_cmd_in),
    .pc_in            (pc_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .imm_in           (imm_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .dest_in          (dest_in),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .sr               (sr),
    .wb_en            (wb_en),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .alu_res          (alu_res),
    .val_rm           (val_rm),
    .dest             (dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, wb, mr, mw, b;
    logic [31:0] pc, rn, rm;
    logic [11:0] so;
    logic [23:0] off;
    logic [3:0]  dst;
    logic [31:0] e_res;
    logic [3:0]  e_sr;
  } vec_t;

  typedef struct {
    logic [31:0] res, rm;
    logic [3:0]  sr, dst;
    logic        wb, mr, mw;
  } exp_t;

  vec_t tbl[22];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    exe_cmd_in       = v.cmd;
    s_in             = v.s;
    imm_in           = v.imm;
    wb_en_in         = v.wb;
    mem_r_en_in      = v.mr;
    mem_w_en_in      = v.mw;
    b_in             = v.b;
    pc_in            = v.pc;
    val_rn_in        = v.rn;
    val_rm_in        = v.rm;
    shift_operand_in = v.so;
    signed_imm_24_in = v.off;
    dest_in          = v.dst;
  endtask

  function automatic exp_t mk_exp(vec_t v);
    exp_t e;
    e.res = v.e_res;
    e.rm  = v.rm;
    e.sr  = v.e_sr;
    e.dst = v.dst;
    e.wb  = v.wb;
    e.mr  = v.mr;
    e.mw  = v.mw;
    return e;
  endfunction

  task automatic chk_regs(string nm, exp_t e);
    chk({nm, ".alu_res"}, alu_res, e.res);
    chk({nm, ".val_rm"}, val_rm, e.rm);
    chk({nm, ".sr"}, {28'b0, sr}, {28'b0, e.sr});
    chk({nm, ".dest"}, {28'b0, dest}, {28'b0, e.dst});
    chk({nm, ".ctl"}, {29'b0, wb_en, mem_r_en, mem_w_en},
        {29'b0, e.wb, e.mr, e.mw});
  endtask

  function automatic vec_t v(
    logic [3:0] cmd, logic s, logic imm,
    logic [2:0] ctl, logic [31:0] rn, logic [31:0] rm,
    logic [11:0] so, logic [3:0] dst,
    logic [31:0] e_res, logic [3:0] e_sr);
    vec_t r;
    r.cmd = cmd; r.s = s; r.imm = imm;
    r.wb = ctl[2]; r.mr = ctl[1]; r.mw = ctl[0];
    r.b = 1'b0; r.pc = 32'h0; r.off = 24'h0;
    r.rn = rn; r.rm = rm; r.so = so; r.dst = dst;
    r.e_res = e_res; r.e_sr = e_sr;
    return r;
  endfunction

  initial begin
    exp_t e;
    vec_t x;
    logic [31:0] want_ba;

    // ADDS overflow, CMP equal, SBC with C=1
    tbl[0]  = v(4'h2, 1, 1, 3'b100, 32'h7FFFFFFF, 0,
                12'h001, 1, 32'h80000000, 4'b1001);
    tbl[1]  = v(4'h4, 1, 0, 3'b000, 5, 5,
                12'h000, 0, 0, 4'b0110);
    tbl[2]  = v(4'h5, 0, 1, 3'b100, 10, 0,
                12'h003, 2, 7, 4'b0110);
    // shifter and rotated immediate
    tbl[3]  = v(4'h1, 0, 1, 3'b100, 0, 0,
                12'h2FF, 3, 32'hF000000F, 4'b0110);
    tbl[4]  = v(4'h1, 0, 0, 3'b100, 0, 32'h80000000,
                12'h240, 4, 32'hF8000000, 4'b0110);
    tbl[5]  = v(4'h1, 0, 0, 3'b100, 0, 32'hAB,
                12'h460, 5, 32'hAB000000, 4'b0110);
    // memory offset beats the immediate rule
    tbl[6]  = v(4'h2, 0, 1, 3'b001, 32'h100, 32'hDEAD,
                12'h104, 6, 32'h204, 4'b0110);
    tbl[7]  = v(4'h2, 0, 0, 3'b110, 32'h100, 32'h1234,
                12'h004, 7, 32'h104, 4'b0110);
    tbl[8]  = v(4'h1, 0, 0, 3'b100, 0, 1,
                12'h280, 8, 32'h20, 4'b0110);
    tbl[9]  = v(4'h1, 0, 0, 3'b100, 0, 32'h80000000,
                12'h220, 9, 32'h08000000, 4'b0110);
    // MVNS keeps C=1, V=0
    tbl[10] = v(4'h9, 1, 1, 3'b100, 0, 0,
                12'h000, 10, 32'hFFFFFFFF, 4'b1010);
    tbl[11] = v(4'h3, 1, 1, 3'b100, 1, 0,
                12'h001, 11, 3, 4'b0000);
    tbl[12] = v(4'h3, 0, 1, 3'b100, 1, 0,
                12'h001, 12, 2, 4'b0000);
    tbl[13] = v(4'h6, 0, 0, 3'b100, 32'hF0F0, 32'hFF00,
                12'h000, 13, 32'hF000, 4'b0000);
    tbl[14] = v(4'h7, 0, 1, 3'b100, 32'hF0, 0,
                12'h00F, 14, 32'hFF, 4'b0000);
    tbl[15] = v(4'h8, 0, 1, 3'b100, 32'hFF, 0,
                12'h00F, 15, 32'hF0, 4'b0000);
    // SUBS borrow, SUBS overflow, TST keeps C/V
    tbl[16] = v(4'h4, 1, 1, 3'b100, 0, 0,
                12'h001, 1, 32'hFFFFFFFF, 4'b1000);
    tbl[17] = v(4'h4, 1, 1, 3'b100, 32'h80000000, 0,
                12'h001, 2, 32'h7FFFFFFF, 4'b0011);
    tbl[18] = v(4'h6, 1, 1, 3'b000, 32'hF0, 0,
                12'h00F, 3, 0, 4'b0111);
    // undefined opcode with S set: result 0, flags held
    tbl[19] = v(4'hF, 1, 0, 3'b000, 5, 0,
                12'h000, 0, 0, 4'b0111);
    tbl[20] = v(4'h2, 1, 1, 3'b100, 32'hFFFFFFFF, 0,
                12'h001, 4, 0, 4'b0110);
    // branch: PC+4=0x20, offset -2 words
    tbl[21] = v(4'h0, 0, 0, 3'b000, 0, 0,
                12'h000, 0, 0, 4'b0110);
    tbl[21].b   = 1'b1;
    tbl[21].pc  = 32'h20;
    tbl[21].off = 24'hFFFFFE;

    // reset with freeze high and random inputs
    rst = 1'b0;
    freeze = 1'b1;
    x = v(4'($urandom), 1, 1'($urandom), 3'($urandom),
          $urandom, $urandom, 12'($urandom), 4'($urandom),
          0, 0);
    drive(x);
    repeat (2) @(posedge clk);
    #1;
    e = '{res: 0, rm: 0, sr: 0, dst: 0,
          wb: 0, mr: 0, mw: 0};
    n_vec++;
    chk_regs("reset", e);

    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i]));
      n_vec++;
      #1;
      want_ba = tbl[i].pc +
        32'($signed(tbl[i].off) * 4);
      chk($sformatf("v%0d.branch_addr", i),
          branch_addr, want_ba);
      chk($sformatf("v%0d.branch_taken", i),
          {31'b0, branch_taken}, {31'b0, tbl[i].b});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_regs($sformatf("v%0d", i), e);
      @(negedge clk);
    end

    // freeze: known state first, then a frozen ADDS
    x = v(4'h1, 0, 1, 3'b100, 0, 0, 12'h055, 3,
          32'h55, 4'b0110);
    drive(x);
    @(posedge clk);
    #1;
    n_vec++;
    chk_regs("pre_freeze", mk_exp(x));
    @(negedge clk);
    x = v(4'h2, 1, 1, 3'b101, 1, 32'h77, 12'h001, 9,
          2, 4'b0000);
    drive(x);
    freeze = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '{res: 32'h55, rm: 0, sr: 4'b0110, dst: 3,
          wb: 1, mr: 0, mw: 0};
    n_vec++;
    chk_regs("frozen", e);
    @(negedge clk);
    freeze = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    chk_regs("unfrozen", mk_exp(x));

    // reset wins over freeze and drops the instruction
    @(negedge clk);
    x = v(4'h2, 1, 1, 3'b110, 32'hFFFFFFFF, 32'h99,
          12'h001, 5, 0, 0);
    drive(x);
    freeze = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    e = '{res: 0, rm: 0, sr: 0, dst: 0,
          wb: 0, mr: 0, mw: 0};
    n_vec++;
    chk_regs("rst_over_freeze", e);
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;
    x = v(4'h0, 0, 0, 3'b000, 0, 0, 12'h000, 0, 0, 0);
    drive(x);
    @(posedge clk);
    #1;
    n_vec++;
    chk_regs("bubble", mk_exp(x));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline (IF, ID, EXE, MEM, WB).
- Consumes the ID/EXE pipeline register outputs, generates Val2 and runs the ALU.
- Owns the 4-bit status register (SR) and computes the branch target for IF.
- Registers its results into the EXE/MEM pipeline register, which feeds MEM.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- REG_AW, 4, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- freeze  in  1  holds the EXE/MEM register and SR
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits from ID/EXE
- exe_cmd_in  in  4  ALU opcode
- pc_in  in  32  PC+4 of this instruction
- val_rn_in, val_rm_in  in  32 each  register operands
- imm_in  in  1  I bit
- shift_operand_in  in  12  instruction bits [11:0]
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  destination register
- branch_taken  out  1  combinational, equals b_in
- branch_addr  out  32  combinational branch target
- sr  out  4  registered {N,Z,C,V}, also fed back to ID condition check
- wb_en, mem_r_en, mem_w_en  out  1 each  registered EXE/MEM controls
- alu_res  out  32  registered ALU result or memory address
- val_rm  out  32  registered store data
- dest  out  4  registered destination register

Behaviour:
- Reset is synchronous: rst==0 at a rising edge clears every registered output and sr to 0.
- Reset is honoured over freeze. An instruction in flight during reset is dropped.
- Latency is 1 cycle from the inputs to the registered outputs.
- If freeze==1 and rst==1, all registers and sr hold their values.
- Val2 selection, first matching rule wins:
  1. mem_r_en_in|mem_w_en_in: Val2 = zero-extended shift_operand_in[11:0].
  2. imm_in: Val2 = {24'b0, so[7:0]} rotated right by 2*so[11:8].
  3. Otherwise shift val_rm_in by so[11:7], type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value unchanged.
- ALU operations by exe_cmd_in:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!C
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: result 0, flags unchanged.
- C and V are taken from a 33-bit sum/difference. For subtraction, C = NOT borrow. For logical/move ops, C and V keep their current sr values.
- N = res[31]. Z = (res==0).
- sr is updated at the edge only when s_in==1, freeze==0 and rst==1.
- ADC/SBC read sr, the value before the current edge.
- alu_res captures the ALU result every unfrozen cycle, including CMP/TST. The CMP/TST case is harmless because ID clears wb_en for them.
- branch_addr = pc_in + {{6{imm24[23]}}, imm24, 2'b00}, computed every cycle regardless of b_in.
- Bubbles: ID inserts bubbles as all-zero controls. They propagate as wb_en=mem_r_en=mem_w_en=0 and leave sr untouched.

Optional Feature:
- Macro EXE_FWD_EN, forwarding mux.
- Defined: adds ports sel_src1, sel_src2 (in, 2 each), mem_fwd_val, wb_fwd_val (in, 32 each).
- Selection per operand: 00 register value, 01 mem_fwd_val, 10 wb_fwd_val, 11 register value.
- The selected Rm feeds both the shifter and the registered val_rm.
- Undefined: those ports do not exist and the operands come straight from the inputs.

Decomposition:
- Package exe_pkg holds:
  - the EXE_CMD opcode localparams,
  - the shift-type constants (LSL/LSR/ASR/ROR),
  - the SR bit indices N=3, Z=2, C=1, V=0.
- One sub-module, val2_generator: combinational Val2 from val_rm, shift_operand, imm, mem_en.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with freeze=1 and random inputs -> all outputs and sr = 0.
2. ADDS: Rn=0x7FFFFFFF, Val2=1 (imm, so=0x001), cmd 0010, s=1 -> alu_res=0x80000000 next cycle, sr=1001 (N,V).
3. SUBS/CMP: Rn=5, Rm=5, so=0x000, cmd 0100, s=1 -> alu_res=0, sr=0110 (Z,C). Follow with SBC Rn=10, Val2=3 -> 7.
4. Shifter and rotate:
   - imm so=0x2FF -> Val2=0xF000000F.
   - Rm=0x80000000, ASR#4 (so=0x240) with MOV -> alu_res=0xF8000000.
   - ROR#8 on 0x000000AB -> 0xAB000000.
5. Memory and branch:
   - mem_w_en=1, Rn=0x100, so=0x004, Rm=0xDEAD -> alu_res=0x104, val_rm=0xDEAD.
   - b_in=1, pc_in=0x20, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0x18.
6. Freeze: during an ADDS with s=1, assert freeze -> outputs and sr unchanged. Deassert freeze -> the update lands on the next edge.
